riscv_mem_arbiter: RTL and testbench

- Shares one single-port unified memory between the core's instruction-fetch requester (I) and its load/store requester (D).
- Sits between the RISC_V core's fetch/data interfaces and the memory.
- Fixed priority to D, with a starvation guard for I.
- One outstanding transaction at a time; all outputs are registered.

---
 rtl/riscv_mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one single-port memory between the instruction
// fetch requester (I) and the load/store requester (D). D has fixed priority,
// but after MAX_STREAK consecutive D grants with I waiting, I is forced ahead.
// One transaction is outstanding at a time and every output is a register.
module riscv_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_spurious
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2} owner_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    state_t              state_r,     state_nxt_s;
    owner_t              owner_r,     owner_nxt_s;
    logic [3:0]          streak_r,    streak_nxt_s;
    logic                mem_req_r,   mem_req_nxt_s;
    logic                mem_we_r,    mem_we_nxt_s;
    logic [ADDR_W-1:0]   mem_addr_r,  mem_addr_nxt_s;
    logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_nxt_s;
    logic                i_ack_r,     i_ack_nxt_s;
    logic                d_ack_r,     d_ack_nxt_s;
    logic [DATA_W-1:0]   i_rdata_r,   i_rdata_nxt_s;
    logic [DATA_W-1:0]   d_rdata_r,   d_rdata_nxt_s;
    logic                err_r,       err_nxt_s;
    logic                grant_d_s;
    logic                grant_i_s;

    // D wins unless I has waited through a full streak of D grants.
    assign grant_d_s = d_req && (!i_req || (streak_r != STREAK_MAX));
    assign grant_i_s = i_req && !grant_d_s;

    assign mem_req      = mem_req_r;
    assign mem_we       = mem_we_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wdata    = mem_wdata_r;
    assign i_ack        = i_ack_r;
    assign d_ack        = d_ack_r;
    assign i_rdata      = i_rdata_r;
    assign d_rdata      = d_rdata_r;
    assign err_spurious = err_r;

    // Next-state, arbitration and next-output computation.
    always_comb begin
        state_nxt_s     = state_r;
        owner_nxt_s     = owner_r;
        streak_nxt_s    = streak_r;
        mem_req_nxt_s   = mem_req_r;
        mem_we_nxt_s    = mem_we_r;
        mem_addr_nxt_s  = mem_addr_r;
        mem_wdata_nxt_s = mem_wdata_r;
        i_ack_nxt_s     = 1'b0;
        d_ack_nxt_s     = 1'b0;
        i_rdata_nxt_s   = i_rdata_r;
        d_rdata_nxt_s   = d_rdata_r;
        // A response is only legitimate while waiting for one.
        err_nxt_s       = err_r | (mem_rvalid && (state_r != WAIT));

        case (state_r)
            IDLE: begin
                if (grant_d_s) begin
                    state_nxt_s     = ISSUE;
                    owner_nxt_s     = OWN_D;
                    mem_req_nxt_s   = 1'b1;
                    mem_we_nxt_s    = d_we;
                    mem_addr_nxt_s  = d_addr;
                    mem_wdata_nxt_s = d_wdata;
                    if (i_req) begin
                        streak_nxt_s = (streak_r == STREAK_MAX) ? STREAK_MAX : (streak_r + 4'd1);
                    end else begin
                        streak_nxt_s = 4'd0;
                    end
                end else if (grant_i_s) begin
                    state_nxt_s     = ISSUE;
                    owner_nxt_s     = OWN_I;
                    mem_req_nxt_s   = 1'b1;
                    mem_we_nxt_s    = 1'b0;
                    mem_addr_nxt_s  = i_addr;
                    mem_wdata_nxt_s = {DATA_W{1'b0}};
                    streak_nxt_s    = 4'd0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    mem_req_nxt_s = 1'b0;
                    state_nxt_s   = WAIT;
                end else begin
                    state_nxt_s = ISSUE;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_nxt_s = RESP;
                    if (owner_r == OWN_I) begin
                        i_ack_nxt_s   = 1'b1;
                        i_rdata_nxt_s = mem_rdata;
                    end else if (owner_r == OWN_D) begin
                        d_ack_nxt_s = 1'b1;
                        if (!mem_we_r) begin
                            d_rdata_nxt_s = mem_rdata;
                        end else begin
                            d_rdata_nxt_s = d_rdata_r;
                        end
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                // The ack is visible this cycle; no arbitration until IDLE.
                state_nxt_s = IDLE;
                owner_nxt_s = OWN_NONE;
            end
            default: begin
                state_nxt_s = IDLE;
                owner_nxt_s = OWN_NONE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            owner_r     <= OWN_NONE;
            streak_r    <= 4'd0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            i_ack_r     <= 1'b0;
            d_ack_r     <= 1'b0;
            i_rdata_r   <= {DATA_W{1'b0}};
            d_rdata_r   <= {DATA_W{1'b0}};
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            owner_r     <= owner_nxt_s;
            streak_r    <= streak_nxt_s;
            mem_req_r   <= mem_req_nxt_s;
            mem_we_r    <= mem_we_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            mem_wdata_r <= mem_wdata_nxt_s;
            i_ack_r     <= i_ack_nxt_s;
            d_ack_r     <= d_ack_nxt_s;
            i_rdata_r   <= i_rdata_nxt_s;
            d_rdata_r   <= d_rdata_nxt_s;
            err_r       <= err_nxt_s;
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Testbench for riscv_mem_arbiter: scoreboard of expected transactions,
// a sequential memory responder, and explicit reset / error scenarios.
module tb_riscv_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        err_spurious;

    typedef struct packed {
        logic        is_d;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_i_rdata = 32'd0;
    logic [31:0] m_d_rdata = 32'd0;

    riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_mem_req"},   32'(mem_req),   32'd0);
        check_eq({tag, "_mem_we"},    32'(mem_we),    32'd0);
        check_eq({tag, "_mem_addr"},  mem_addr,       32'd0);
        check_eq({tag, "_mem_wdata"}, mem_wdata,      32'd0);
        check_eq({tag, "_i_ack"},     32'(i_ack),     32'd0);
        check_eq({tag, "_d_ack"},     32'(d_ack),     32'd0);
        check_eq({tag, "_i_rdata"},   i_rdata,        32'd0);
        check_eq({tag, "_d_rdata"},   d_rdata,        32'd0);
        check_eq({tag, "_err"},       32'(err_spurious), 32'd0);
    endtask

    // Serve the next memory transaction and check it against the scoreboard.
    task automatic serve(input int gnt_wait, input bit drop);
        txn_t e;
        for (int k = 0; k < 20 && (mem_req !== 1'b1); k++) tick();
        check_eq("mem_req_rise", 32'(mem_req), 32'd1);
        if (exp_q.size() == 0) begin
            check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        for (int k = 0; k <= gnt_wait; k++) begin
            check_eq("hold_mem_req",   32'(mem_req), 32'd1);
            check_eq("hold_mem_addr",  mem_addr,     e.addr);
            check_eq("hold_mem_we",    32'(mem_we),  32'(e.we));
            check_eq("hold_mem_wdata", mem_wdata,    e.wdata);
            if (k < gnt_wait) tick();
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check_eq("mem_req_drop", 32'(mem_req), 32'd0);
        check_eq("wait_i_ack",   32'(i_ack),   32'd0);
        check_eq("wait_d_ack",   32'(d_ack),   32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = e.we ? (32'h5A5A0000 ^ e.addr) : e.rdata;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        check_eq("ack_i", 32'(i_ack), 32'(!e.is_d));
        check_eq("ack_d", 32'(d_ack), 32'(e.is_d));
        if (!e.we) begin
            if (e.is_d) m_d_rdata = e.rdata;
            else        m_i_rdata = e.rdata;
        end
        check_eq("i_rdata", i_rdata, m_i_rdata);
        check_eq("d_rdata", d_rdata, m_d_rdata);
        if (drop) begin
            if (e.is_d) d_req = 1'b0;
            else        i_req = 1'b0;
        end
        tick();
        check_eq("post_ack_i",     32'(i_ack),   32'd0);
        check_eq("post_ack_d",     32'(d_ack),   32'd0);
        check_eq("no_regrant_resp", 32'(mem_req), 32'd0);
    endtask

    initial begin
        txn_t t;
        reset = 1'b1; i_req = 1'b0; i_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 32'd0; d_wdata = 32'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        tick(); tick();
        reset = 1'b0;
        check_idle_outputs("reset");

        // Single I read at 0x10: mem_req must rise one cycle after i_req.
        i_req = 1'b1; i_addr = 32'h10;
        t = '{is_d: 1'b0, addr: 32'h10, we: 1'b0, wdata: 32'd0, rdata: 32'hDEADBEEF};
        exp_q.push_back(t);
        tick();
        check_eq("i_first_latency", 32'(mem_req), 32'd1);
        serve(0, 1'b1);

        // D store with the grant held off for three cycles.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hCAFEF00D;
        t = '{is_d: 1'b1, addr: 32'h200, we: 1'b1, wdata: 32'hCAFEF00D, rdata: 32'd0};
        exp_q.push_back(t);
        serve(3, 1'b1);
        d_we = 1'b0; d_wdata = 32'd0;

        // Both requesters held: D four times, then I is forced ahead.
        i_addr = 32'h100; d_addr = 32'h300;
        for (int g = 0; g < 10; g++) begin
            t.is_d  = ((g % 5) != 4);
            t.addr  = t.is_d ? 32'h300 : 32'h100;
            t.we    = 1'b0;
            t.wdata = 32'd0;
            t.rdata = 32'h10000000 + 32'(g);
            exp_q.push_back(t);
        end
        i_req = 1'b1; d_req = 1'b1;
        for (int g = 0; g < 10; g++) serve(0, 1'b0);
        i_req = 1'b0; d_req = 1'b0;
        tick(); tick();
        check_eq("quiet_mem_req", 32'(mem_req), 32'd0);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        check_eq("err_clean", 32'(err_spurious), 32'd0);

        // Reset while waiting for a response, then a late response.
        i_req = 1'b1; i_addr = 32'h40;
        for (int k = 0; k < 20 && (mem_req !== 1'b1); k++) tick();
        check_eq("rst_wait_req", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        reset = 1'b1; i_req = 1'b0;
        tick();
        reset = 1'b0;
        m_i_rdata = 32'd0; m_d_rdata = 32'd0;
        check_idle_outputs("rst_in_wait");
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'd0;
        check_eq("late_rvalid_err",  32'(err_spurious), 32'd1);
        check_eq("late_rvalid_iack", 32'(i_ack), 32'd0);
        tick();
        check_eq("late_rvalid_iack2", 32'(i_ack), 32'd0);
        check_eq("late_rvalid_rdata", i_rdata, 32'd0);

        // Spurious response in IDLE is sticky until reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("err_after_reset", 32'(err_spurious), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF0000;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'd0;
        check_eq("idle_rvalid_err", 32'(err_spurious), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("err_sticky", 32'(err_spurious), 32'd1);
            check_eq("idle_rvalid_iack", 32'(i_ack), 32'd0);
            check_eq("idle_rvalid_dack", 32'(d_ack), 32'd0);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("err_cleared", 32'(err_spurious), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
